// File: rtl/neuro_pkg.sv
// Shared encodings and the saturating clamp used by the neuron update datapath.
// The clamp works on a wide signed value so sums and scaled products never wrap first.
package neuro_pkg;

    typedef enum logic [1:0] {
        MODEL_LIF     = 2'd0,
        MODEL_IZHI_AD = 2'd1,
        MODEL_QLIF    = 2'd2,
        MODEL_RSVD    = 2'd3
    } model_e;

    typedef enum logic [2:0] {
        CFG_A    = 3'd0,
        CFG_B    = 3'd1,
        CFG_C    = 3'd2,
        CFG_D    = 3'd3,
        CFG_VTH  = 3'd4,
        CFG_REF  = 3'd5,
        CFG_U    = 3'd6,
        CFG_NONE = 3'd7
    } cfg_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SUM     = 3'd1,
        ST_EVAL    = 3'd2,
        ST_MUL_BV  = 3'd3,
        ST_MUL_ABV = 3'd4,
        ST_OUT     = 3'd5
    } state_e;

    // Must exceed twice the widest datapath so products fit before clamping.
    localparam int SAT_W = 128;

    function automatic logic signed [SAT_W-1:0] sat_wide(input logic signed [SAT_W-1:0] x,
                                                        input int unsigned w);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
        min_v = ~max_v;
        if (x > max_v) return max_v;
        if (x < min_v) return min_v;
        return x;
    endfunction

endpackage

// File: rtl/seq_mul.sv
// Iterative signed shift-add multiplier: one partial product per cycle, the sign
// bit's partial product is subtracted and folded into the done cycle combinationally.
module seq_mul #(
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic                       done,
    output logic signed [2*DATA_W-1:0] product
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic                busy_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [2*DATA_W-1:0] acc_reg;
    logic [2*DATA_W-1:0] mc_reg;
    logic [DATA_W-1:0]   mp_reg;

    logic                last_bit;
    logic [2*DATA_W-1:0] pp;
    logic [2*DATA_W-1:0] acc_next;

    assign last_bit = (cnt_reg == CNT_W'(DATA_W - 1));
    assign pp       = mp_reg[0] ? mc_reg : '0;
    assign acc_next = last_bit ? (acc_reg - pp) : (acc_reg + pp);
    assign done     = busy_reg && last_bit;
    assign product  = $signed(acc_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
            acc_reg  <= '0;
            mc_reg   <= '0;
            mp_reg   <= '0;
        end else if (start) begin
            busy_reg <= 1'b1;
            cnt_reg  <= '0;
            acc_reg  <= '0;
            mc_reg   <= {{DATA_W{a[DATA_W-1]}}, a};
            mp_reg   <= b;
        end else if (busy_reg) begin
            if (last_bit) begin
                busy_reg <= 1'b0;
            end else begin
                acc_reg <= acc_next;
                mc_reg  <= mc_reg << 1;
                mp_reg  <= mp_reg >> 1;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/neuron_update_unit.sv
// Time-multiplexed membrane update for LIF, QLIF and adaptive Izhikevich neurons,
// with per-neuron recovery and refractory state and valid/ready on both sides.
module neuron_update_unit
    import neuro_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int FRAC_W    = 16,
    parameter int N_NEURONS = 8,
    parameter int REF_W     = 4,
    parameter int ID_W      = $clog2(N_NEURONS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               model,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ID_W-1:0]          in_id,
    input  logic signed [DATA_W-1:0] in_weight,
    input  logic signed [DATA_W-1:0] in_vdec,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ID_W-1:0]          out_id,
    output logic signed [DATA_W-1:0] out_v,
    output logic                     out_spike,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_sel,
    input  logic [ID_W-1:0]          cfg_id,
    input  logic signed [DATA_W-1:0] cfg_data
);

    function automatic logic signed [SAT_W-1:0] ext(input logic signed [DATA_W-1:0] x);
        return SAT_W'(x);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_d(input logic signed [SAT_W-1:0] x);
        return DATA_W'(sat_wide(x, DATA_W));
    endfunction

    function automatic logic signed [DATA_W-1:0] scale(input logic signed [2*DATA_W-1:0] p);
        return sat_d(SAT_W'(p >>> FRAC_W));
    endfunction

    state_e state_reg, state_next;

    logic [ID_W-1:0]          id_reg;
    logic signed [DATA_W-1:0] w_reg, vdec_reg, s_reg;
    model_e                   model_reg;
    logic                     refr_reg, spike_reg;
    logic [ID_W-1:0]          out_id_reg;
    logic signed [DATA_W-1:0] out_v_reg;
    logic                     out_spike_reg;

    logic signed [DATA_W-1:0] a_reg, b_reg, c_reg, d_reg, v_th_reg;
    logic [REF_W-1:0]         ref_period_reg;

    logic signed [DATA_W-1:0] u_mem   [N_NEURONS];
    logic [REF_W-1:0]         ref_mem [N_NEURONS];

    logic                       is_izhi, spike_eval, u_wb;
    logic signed [DATA_W-1:0]   u_cur, s_sum, v_lif, t_bv, abv_scaled, u_new;
    logic [REF_W-1:0]           ref_cur;
    logic                       mul_start, mul_done;
    logic signed [DATA_W-1:0]   mul_a, mul_b;
    logic signed [2*DATA_W-1:0] mul_p;
    logic [N_NEURONS-1:0]       sel_hit, cfg_u_hit;

    assign is_izhi    = (model_reg == MODEL_IZHI_AD);
    assign u_cur      = u_mem[id_reg];
    assign ref_cur    = ref_mem[id_reg];
    assign s_sum      = is_izhi ? sat_d(ext(w_reg) + ext(vdec_reg) - ext(u_cur))
                                : sat_d(ext(w_reg) + ext(vdec_reg));
    assign spike_eval = (s_reg > v_th_reg);
    assign v_lif      = spike_eval ? sat_d(ext(s_reg) - ext(v_th_reg)) : s_reg;
    assign abv_scaled = scale(mul_p);
    assign t_bv       = sat_d(ext(abv_scaled) - ext(u_cur));
    assign u_new      = spike_reg ? sat_d(ext(u_cur) + ext(d_reg))
                                  : sat_d(ext(u_cur) + ext(abv_scaled));
    assign u_wb       = (state_reg == ST_MUL_ABV) && mul_done;

    assign in_ready   = (state_reg == ST_IDLE);
    assign out_valid  = (state_reg == ST_OUT);
    assign out_id     = out_id_reg;
    assign out_v      = out_v_reg;
    assign out_spike  = out_spike_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_NEURONS; gi++) begin : g_hit
            assign sel_hit[gi]   = (id_reg == ID_W'(gi));
            assign cfg_u_hit[gi] = cfg_we && (cfg_sel_e'(cfg_sel) == CFG_U) && (cfg_id == ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // The same multiplier serves b*vdec and then a*t; t feeds straight from the first product.
    always_comb begin
        state_next = state_reg;
        mul_start  = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        case (state_reg)
            ST_IDLE: if (in_valid) state_next = ST_SUM;
            ST_SUM:  state_next = ST_EVAL;
            ST_EVAL: begin
                if (!refr_reg && is_izhi) begin
                    mul_start  = 1'b1;
                    mul_a      = b_reg;
                    mul_b      = vdec_reg;
                    state_next = ST_MUL_BV;
                end else begin
                    state_next = ST_OUT;
                end
            end
            ST_MUL_BV: begin
                if (mul_done) begin
                    mul_start  = 1'b1;
                    mul_a      = a_reg;
                    mul_b      = t_bv;
                    state_next = ST_MUL_ABV;
                end
            end
            ST_MUL_ABV: if (mul_done) state_next = ST_OUT;
            ST_OUT:     if (out_ready) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_reg        <= '0;
            w_reg         <= '0;
            vdec_reg      <= '0;
            s_reg         <= '0;
            model_reg     <= MODEL_LIF;
            refr_reg      <= 1'b0;
            spike_reg     <= 1'b0;
            out_id_reg    <= '0;
            out_v_reg     <= '0;
            out_spike_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        id_reg    <= in_id;
                        w_reg     <= in_weight;
                        vdec_reg  <= in_vdec;
                        model_reg <= model_e'(model);
                    end
                end
                ST_SUM: begin
                    s_reg    <= s_sum;
                    refr_reg <= (ref_cur != '0);
                end
                ST_EVAL: begin
                    out_id_reg <= id_reg;
                    if (refr_reg) begin
                        spike_reg     <= 1'b0;
                        out_spike_reg <= 1'b0;
                        out_v_reg     <= is_izhi ? c_reg : '0;
                    end else begin
                        spike_reg     <= spike_eval;
                        out_spike_reg <= spike_eval;
                        case (model_reg)
                            MODEL_IZHI_AD: out_v_reg <= spike_eval ? c_reg : s_reg;
                            MODEL_QLIF:    out_v_reg <= spike_eval ? '0 : s_reg;
                            default:       out_v_reg <= v_lif;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // A configuration write to u beats a same-cycle recovery writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                u_mem[i]   <= '0;
                ref_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_NEURONS; i++) begin
                if (cfg_u_hit[i])             u_mem[i] <= cfg_data;
                else if (u_wb && sel_hit[i])  u_mem[i] <= u_new;
                if (sel_hit[i]) begin
                    if (state_reg == ST_EVAL && refr_reg)
                        ref_mem[i] <= ref_mem[i] - REF_W'(1);
                    else if (state_reg == ST_EVAL && model_reg == MODEL_QLIF && spike_eval)
                        ref_mem[i] <= ref_period_reg;
                    else if (u_wb && spike_reg)
                        ref_mem[i] <= ref_period_reg;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg          <= '0;
            b_reg          <= '0;
            c_reg          <= '0;
            d_reg          <= '0;
            v_th_reg       <= '0;
            ref_period_reg <= '0;
        end else if (cfg_we) begin
            case (cfg_sel_e'(cfg_sel))
                CFG_A:   a_reg          <= cfg_data;
                CFG_B:   b_reg          <= cfg_data;
                CFG_C:   c_reg          <= cfg_data;
                CFG_D:   d_reg          <= cfg_data;
                CFG_VTH: v_th_reg       <= cfg_data;
                CFG_REF: ref_period_reg <= cfg_data[REF_W-1:0];
                default: ;
            endcase
        end
    end

    seq_mul #(.DATA_W(DATA_W)) u_seq_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (mul_a),
        .b       (mul_b),
        .done    (mul_done),
        .product (mul_p)
    );

endmodule

// File: tb/tb_neuron_update_unit.sv
// Scoreboard bench for neuron_update_unit: expected results are queued when an
// update is driven and compared when the unit presents its output.
module tb_neuron_update_unit;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [1:0]         model;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_id;
    logic signed [31:0] in_weight;
    logic signed [31:0] in_vdec;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         out_id;
    logic signed [31:0] out_v;
    logic               out_spike;
    logic               cfg_we;
    logic [2:0]         cfg_sel;
    logic [2:0]         cfg_id;
    logic signed [31:0] cfg_data;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] v;
        logic        spike;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic [31:0] vth_now;

    always #5 clk = ~clk;

    neuron_update_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .model     (model),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_id     (in_id),
        .in_weight (in_weight),
        .in_vdec   (in_vdec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_v     (out_v),
        .out_spike (out_spike),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_id    (cfg_id),
        .cfg_data  (cfg_data)
    );

    function automatic logic [31:0] bsat(input longint x);
        if (x > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (x < -64'sd2147483648) return 32'h8000_0000;
        return x[31:0];
    endfunction

    task automatic cfg_write(input logic [2:0] sel, input logic [2:0] id, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_id = id; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        if (sel == 3'd4) vth_now = d;
    endtask

    task automatic do_update(input logic [1:0] m, input logic [2:0] id, input logic [31:0] w,
                             input logic [31:0] vd, input logic [31:0] ev, input logic es,
                             input int elat, input int hold, input string name);
        exp_t e;
        int   n;
        int   lat;
        e.id = id; e.v = ev; e.spike = es;
        sb.push_back(e);
        out_ready = (hold == 0);
        @(negedge clk);
        model = m; in_id = id; in_weight = w; in_vdec = vd; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s accept: in_ready=%b required 1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        e = sb.pop_front();
        checks++;
        if (lat !== elat) begin
            errors++; $display("FAIL %s latency: got %0d required %0d", name, lat, elat);
        end
        checks++;
        if (out_v !== e.v) begin
            errors++; $display("FAIL %s out_v: got %h required %h", name, out_v, e.v);
        end
        checks++;
        if (out_spike !== e.spike) begin
            errors++; $display("FAIL %s out_spike: got %b required %b", name, out_spike, e.spike);
        end
        checks++;
        if (out_id !== e.id) begin
            errors++; $display("FAIL %s out_id: got %0d required %0d", name, out_id, e.id);
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_v !== e.v || out_spike !== e.spike || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s stall%0d: valid=%b v=%h rdy=%b required 1 %h 0",
                         name, k, out_valid, out_v, in_ready, e.v);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL %s release: out_valid=%b required 0", name, out_valid);
        end
        $display("txn %-8s id=%0d v=%h spike=%b lat=%0d", name, id, e.v, e.spike, lat);
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || out_v !== 32'h0 || out_spike !== 1'b0 || out_id !== 3'd0) begin
            errors++;
            $display("FAIL reset outputs: valid=%b v=%h spike=%b id=%0d required 0", out_valid, out_v, out_spike, out_id);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_lif();
        cfg_write(3'd4, 3'd0, 32'h0001_0000);
        do_update(2'd0, 3'd2, 32'h0000_8000, 32'h0000_C000, 32'h0000_4000, 1'b1, 2, 0, "lif_spk");
        do_update(2'd0, 3'd2, 32'h0000_4000, 32'h0000_4000, 32'h0000_8000, 1'b0, 2, 0, "lif_sub");
        do_update(2'd3, 3'd6, 32'h0000_8000, 32'h0000_C000, 32'h0000_4000, 1'b1, 2, 0, "rsvd");
        do_update(2'd0, 3'd7, 32'h0000_8000, 32'h0000_8000, 32'h0001_0000, 1'b0, 2, 0, "lif_eq");
        do_update(2'd0, 3'd7, 32'hFFFF_0000, 32'h0000_0000, 32'hFFFF_0000, 1'b0, 2, 0, "lif_neg");
    endtask

    task automatic test_qlif();
        cfg_write(3'd5, 3'd0, 32'h0000_0002);
        do_update(2'd2, 3'd5, 32'h0000_8000, 32'h0000_C000, 32'h0, 1'b1, 2, 0, "qlif_spk");
        do_update(2'd2, 3'd5, 32'h0000_8000, 32'h0000_C000, 32'h0, 1'b0, 2, 0, "qlif_r1");
        do_update(2'd2, 3'd5, 32'h0000_8000, 32'h0000_C000, 32'h0, 1'b0, 2, 0, "qlif_r2");
        do_update(2'd2, 3'd5, 32'h0000_4000, 32'h0000_4000, 32'h0000_8000, 1'b0, 2, 0, "qlif_int");
    endtask

    task automatic test_izhi();
        cfg_write(3'd0, 3'd0, 32'h0000_8000);
        cfg_write(3'd1, 3'd0, 32'h0001_0000);
        cfg_write(3'd4, 3'd0, 32'h0010_0000);
        cfg_write(3'd6, 3'd3, 32'h0000_4000);
        do_update(2'd1, 3'd3, 32'h0001_0000, 32'h0001_0000, 32'h0001_C000, 1'b0, 66, 0, "izhi");
        do_update(2'd1, 3'd3, 32'h0, 32'h0, 32'hFFFF_6000, 1'b0, 66, 0, "izhi_u3");
        cfg_write(3'd2, 3'd0, 32'hFFFF_0000);
        cfg_write(3'd3, 3'd0, 32'h0000_2000);
        do_update(2'd1, 3'd4, 32'h0010_0000, 32'h0001_0000, 32'hFFFF_0000, 1'b1, 66, 0, "izhi_spk");
        do_update(2'd1, 3'd4, 32'h0010_0000, 32'h0001_0000, 32'hFFFF_0000, 1'b0, 2, 0, "izhi_r1");
        do_update(2'd1, 3'd4, 32'h0010_0000, 32'h0001_0000, 32'hFFFF_0000, 1'b0, 2, 0, "izhi_r2");
        do_update(2'd1, 3'd4, 32'h0, 32'h0, 32'hFFFF_E000, 1'b0, 66, 0, "izhi_u4");
    endtask

    task automatic test_backpressure_isolation();
        cfg_write(3'd6, 3'd0, 32'h0000_4000);
        cfg_write(3'd6, 3'd1, 32'h0000_8000);
        do_update(2'd1, 3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0001_C000, 1'b0, 66, 5, "bp_izhi");
        do_update(2'd1, 3'd1, 32'h0, 32'h0, 32'hFFFF_8000, 1'b0, 66, 0, "iso_u1");
        do_update(2'd1, 3'd0, 32'h0, 32'h0, 32'hFFFF_6000, 1'b0, 66, 0, "iso_u0");
        do_update(2'd0, 3'd2, 32'h0000_8000, 32'h0000_4000, 32'h0000_C000, 1'b0, 2, 5, "bp_lif");
    endtask

    task automatic test_saturation();
        cfg_write(3'd4, 3'd0, 32'h7FFF_FFFF);
        do_update(2'd0, 3'd2, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_FFFF, 1'b0, 2, 0, "sat_pos");
        do_update(2'd0, 3'd2, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 2, 0, "sat_neg");
        cfg_write(3'd4, 3'd0, 32'h8000_0000);
        do_update(2'd0, 3'd2, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_FFFF, 1'b1, 2, 0, "sat_sub");
    endtask

    task automatic test_back_to_back();
        cfg_write(3'd4, 3'd0, 32'h0001_0000);
        for (int k = 0; k < 8; k++) begin
            logic [31:0] w;
            logic [31:0] vd;
            logic [31:0] s;
            logic [31:0] ev;
            logic        es;
            logic [2:0]  id;
            w  = $urandom_range(0, 32'h3FFFF) - 32'h20000;
            vd = $urandom_range(0, 32'h3FFFF) - 32'h20000;
            id = 3'($urandom_range(0, 3));
            s  = bsat(longint'($signed(w)) + longint'($signed(vd)));
            es = ($signed(s) > $signed(vth_now));
            ev = es ? bsat(longint'($signed(s)) - longint'($signed(vth_now))) : s;
            do_update(2'd0, id, w, vd, ev, es, 2, 0, "b2b");
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        model = 2'd1; in_id = 3'd0; in_weight = 32'h0001_0000; in_vdec = 32'h0001_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_v !== 32'h0 || out_spike !== 1'b0 || out_id !== 3'd0) begin
            errors++;
            $display("FAIL midreset outputs: valid=%b v=%h spike=%b id=%0d required 0", out_valid, out_v, out_spike, out_id);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset in_ready: got %b required 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        vth_now = 32'h0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset release: rdy=%b valid=%b required 1 0", in_ready, out_valid);
        end
        do_update(2'd1, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 66, 0, "rst_u0");
        do_update(2'd0, 3'd0, 32'h0000_8000, 32'h0000_C000, 32'h0001_4000, 1'b1, 2, 0, "rst_lif");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; model = 2'd0; in_valid = 1'b0; in_id = '0; in_weight = '0; in_vdec = '0;
        out_ready = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_id = '0; cfg_data = '0; vth_now = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_lif();
        test_qlif();
        test_izhi();
        test_backpressure_isolation();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
